// File: rtl/ccc_setlen_capture_pkg.sv
// rtl/ccc_setlen_capture_pkg.sv - CCC codes and FSM state type for SETMWL/SETMRL capture (SETMRL_IBIL_EN adds BYTE_IBI)
package ccc_setlen_capture_pkg;

    localparam logic [7:0] CCC_SETMWL_BC  = 8'h09;
    localparam logic [7:0] CCC_SETMRL_BC  = 8'h0A;
    localparam logic [7:0] CCC_SETMWL_DIR = 8'h89;
    localparam logic [7:0] CCC_SETMRL_DIR = 8'h8A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ADDR,
        ST_BYTE_HI,
        ST_BYTE_LO,
`ifdef SETMRL_IBIL_EN
        ST_BYTE_IBI,
`endif
        ST_DONE,
        ST_SKIP
    } setlen_state_e;

    // A frame cut short here leaves a length half-received.
    function automatic logic len_pending(setlen_state_e s);
        return (s == ST_BYTE_HI) || (s == ST_BYTE_LO);
    endfunction

endpackage

// File: rtl/ccc_setlen_capture_if.sv
// rtl/ccc_setlen_capture_if.sv - byte receiver / config block signals of the SETMWL/SETMRL capture stage
interface ccc_setlen_capture_if;
    logic        ccc_valid_i;
    logic [7:0]  ccc_i;
    logic        addr_valid_i;
    logic [6:0]  addr_i;
    logic        addr_rnw_i;
    logic [6:0]  target_dyn_addr_i;
    logic        target_dyn_addr_valid_i;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o;
    logic        parity_err_i;
    logic        rstart_i;
    logic        stop_i;
    logic        set_mwl_o;
    logic        set_mrl_o;
    logic        set_ibil_o;
    logic [15:0] mwl_o;
    logic [15:0] mrl_o;
    logic [7:0]  ibil_o;
    logic        busy_o;
    logic        err_o;

    modport master (
        output ccc_valid_i, ccc_i, addr_valid_i, addr_i, addr_rnw_i,
               target_dyn_addr_i, target_dyn_addr_valid_i, byte_valid_i, byte_i,
               parity_err_i, rstart_i, stop_i,
        input  byte_ready_o, set_mwl_o, set_mrl_o, set_ibil_o, mwl_o, mrl_o,
               ibil_o, busy_o, err_o
    );

    modport slave (
        input  ccc_valid_i, ccc_i, addr_valid_i, addr_i, addr_rnw_i,
               target_dyn_addr_i, target_dyn_addr_valid_i, byte_valid_i, byte_i,
               parity_err_i, rstart_i, stop_i,
        output byte_ready_o, set_mwl_o, set_mrl_o, set_ibil_o, mwl_o, mrl_o,
               ibil_o, busy_o, err_o
    );
endinterface

// File: rtl/ccc_setlen_capture.sv
// rtl/ccc_setlen_capture.sv - SETMWL/SETMRL payload capture; SETMRL_IBIL_EN enables the optional IBI length byte
module ccc_setlen_capture
    import ccc_setlen_capture_pkg::*;
#(
    parameter int MIN_LEN = 8
) (
    input logic                 clk_i,
    input logic                 rst_i,
    ccc_setlen_capture_if.slave bus
);

    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);

    setlen_state_e state;
    logic [7:0]    hi_q;
    logic          is_mrl_q;
    logic          is_dir_q;
    logic [15:0]   mwl_q;
    logic [15:0]   mrl_q;
    logic          set_mwl_q;
    logic          set_mrl_q;
    logic          err_q;
    logic          byte_ready;
    logic          take_byte;
    logic          in_byte_state;
    logic          addr_match;
    logic [15:0]   len_w;

    always_comb begin
        byte_ready = 1'b0;
        case (state)
            ST_BYTE_HI, ST_BYTE_LO, ST_DONE, ST_SKIP: byte_ready = 1'b1;
`ifdef SETMRL_IBIL_EN
            ST_BYTE_IBI:                              byte_ready = 1'b1;
`endif
            default:                                  byte_ready = 1'b0;
        endcase
    end

`ifdef SETMRL_IBIL_EN
    assign in_byte_state = len_pending(state) || (state == ST_BYTE_IBI);
`else
    assign in_byte_state = len_pending(state);
`endif

    // Frame terminators and parity errors outrank a coincident byte.
    assign take_byte  = bus.byte_valid_i && byte_ready && !bus.stop_i
                        && !bus.rstart_i && !bus.parity_err_i;
    assign addr_match = bus.target_dyn_addr_valid_i && !bus.addr_rnw_i
                        && (bus.addr_i == bus.target_dyn_addr_i);
    assign len_w      = {hi_q, bus.byte_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            hi_q      <= '0;
            is_mrl_q  <= 1'b0;
            is_dir_q  <= 1'b0;
            mwl_q     <= '0;
            mrl_q     <= '0;
            set_mwl_q <= 1'b0;
            set_mrl_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            set_mwl_q <= 1'b0;
            set_mrl_q <= 1'b0;
            err_q     <= 1'b0;
            if (state == ST_IDLE) begin
                if (bus.ccc_valid_i) begin
                    case (bus.ccc_i)
                        CCC_SETMWL_BC:  begin is_mrl_q <= 1'b0; is_dir_q <= 1'b0; state <= ST_BYTE_HI;   end
                        CCC_SETMRL_BC:  begin is_mrl_q <= 1'b1; is_dir_q <= 1'b0; state <= ST_BYTE_HI;   end
                        CCC_SETMWL_DIR: begin is_mrl_q <= 1'b0; is_dir_q <= 1'b1; state <= ST_WAIT_ADDR; end
                        CCC_SETMRL_DIR: begin is_mrl_q <= 1'b1; is_dir_q <= 1'b1; state <= ST_WAIT_ADDR; end
                        default:        state <= ST_IDLE;
                    endcase
                end
            end else if (bus.stop_i) begin
                err_q <= len_pending(state);
                state <= ST_IDLE;
            end else if (bus.rstart_i && state != ST_WAIT_ADDR) begin
                err_q <= len_pending(state);
                state <= is_dir_q ? ST_WAIT_ADDR : ST_IDLE;
            end else if (bus.parity_err_i && in_byte_state) begin
                err_q <= 1'b1;
                state <= ST_SKIP;
            end else if (state == ST_WAIT_ADDR) begin
                if (bus.addr_valid_i) state <= addr_match ? ST_BYTE_HI : ST_SKIP;
            end else if (take_byte) begin
                case (state)
                    ST_BYTE_HI: begin
                        hi_q  <= bus.byte_i;
                        state <= ST_BYTE_LO;
                    end
                    ST_BYTE_LO: begin
                        if (len_w >= MIN_LEN_W) begin
                            if (is_mrl_q) begin
                                mrl_q     <= len_w;
                                set_mrl_q <= 1'b1;
                            end else begin
                                mwl_q     <= len_w;
                                set_mwl_q <= 1'b1;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
`ifdef SETMRL_IBIL_EN
                        state <= is_mrl_q ? ST_BYTE_IBI : ST_DONE;
`else
                        state <= ST_DONE;
`endif
                    end
`ifdef SETMRL_IBIL_EN
                    ST_BYTE_IBI: state <= ST_DONE;
`endif
                    default: state <= state;
                endcase
            end
        end
    end

`ifdef SETMRL_IBIL_EN
    logic [7:0] ibil_q;
    logic       set_ibil_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ibil_q     <= '0;
            set_ibil_q <= 1'b0;
        end else begin
            set_ibil_q <= (state == ST_BYTE_IBI) && take_byte;
            if ((state == ST_BYTE_IBI) && take_byte) ibil_q <= bus.byte_i;
        end
    end

    assign bus.ibil_o     = ibil_q;
    assign bus.set_ibil_o = set_ibil_q;
`else
    assign bus.ibil_o     = 8'h00;
    assign bus.set_ibil_o = 1'b0;
`endif

    assign bus.byte_ready_o = byte_ready;
    assign bus.busy_o       = (state != ST_IDLE);
    assign bus.set_mwl_o    = set_mwl_q;
    assign bus.set_mrl_o    = set_mrl_q;
    assign bus.mwl_o        = mwl_q;
    assign bus.mrl_o        = mrl_q;
    assign bus.err_o        = err_q;

endmodule
